// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dm_pkg;

  localparam int DM_AW = 8;
  localparam int DM_DW = 8;

  localparam int PORT_CORE  = 0;
  localparam int PORT_STACK = 1;

  typedef enum logic [2:0] {
    DM_IDLE    = 3'd0,
    DM_WR      = 3'd1,
    DM_RD      = 3'd2,
    DM_RD_WAIT = 3'd3,
    DM_ERR     = 3'd4
  } dm_state_e;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-pin bundle of the data-memory arbiter.
interface dm_arbiter_if;
  import dm_pkg::*;

  logic [1:0]       req_i;
  logic [1:0]       we_i;
  logic [DM_AW-1:0] addr0_i;
  logic [DM_AW-1:0] addr1_i;
  logic [DM_DW-1:0] wdata0_i;
  logic [DM_DW-1:0] wdata1_i;
  logic [1:0]       gnt_o;
  logic [1:0]       ack_o;
  logic             err_o;
  logic [DM_DW-1:0] rdata_o;
  logic             busy_o;
  logic             mem_e_o;
  logic             mem_we_o;
  logic [DM_AW-1:0] mem_addr_o;
  logic [DM_DW-1:0] mem_di_o;
  logic [DM_DW-1:0] mem_do_i;

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_do_i,
    output gnt_o, ack_o, err_o, rdata_o, busy_o,
           mem_e_o, mem_we_o, mem_addr_o, mem_di_o
  );

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_do_i,
    input  gnt_o, ack_o, err_o, rdata_o, busy_o,
           mem_e_o, mem_we_o, mem_addr_o, mem_di_o
  );

endinterface

// File: rtl/dm_rr_pick.sv
// Two-way request picker: round-robin against the last owner, or port 0 first.
module dm_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (rr_en && !last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and read/write sequencer in front of the single-port data memory.
// state      | meaning
// S_IDLE     | sampling requests; mem pins parked at 0
// S_WR       | mem_we_o high, memory writes at the end of this cycle
// S_RD       | mem_e_o high, memory registers read data at the end of this cycle
// S_RD_WAIT  | mem_e_o held so memory drives DO; rdata captured at the end
// S_ERR      | address out of range; no pins asserted, error ack follows
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DEPTH = 33,
  parameter int RR    = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  dm_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'(DM_IDLE);
  localparam logic [2:0] S_WR      = 3'(DM_WR);
  localparam logic [2:0] S_RD      = 3'(DM_RD);
  localparam logic [2:0] S_RD_WAIT = 3'(DM_RD_WAIT);
  localparam logic [2:0] S_ERR     = 3'(DM_ERR);

  localparam logic [DM_AW:0] DEPTH_W = (DM_AW+1)'(DEPTH);

  logic [2:0]       state;
  logic             owner;
  logic             last;
  logic [1:0]       win;
  logic [1:0]       gnt_q;
  logic [1:0]       ack_q;
  logic             err_q;
  logic             busy_q;
  logic             mem_e_q;
  logic             mem_we_q;
  logic [DM_AW-1:0] mem_addr_q;
  logic [DM_DW-1:0] mem_di_q;
  logic [DM_DW-1:0] rdata_q;

  logic             sel;
  logic             sel_we;
  logic             sel_oor;
  logic [DM_AW-1:0] sel_addr;
  logic [DM_DW-1:0] sel_wdata;

  dm_rr_pick u_pick (
    .req   (bus.req_i),
    .last  (last),
    .rr_en (RR != 0),
    .win   (win)
  );

  always_comb begin
    sel       = win[PORT_STACK];
    sel_we    = bus.we_i[sel];
    sel_addr  = sel ? bus.addr1_i  : bus.addr0_i;
    sel_wdata = sel ? bus.wdata1_i : bus.wdata0_i;
    sel_oor   = {1'b0, sel_addr} >= DEPTH_W;
  end

  // The mem_addr/mem_di registers double as the latched request, so later
  // requester input changes cannot reach the memory.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_e_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
      rdata_q    <= '0;
    end else begin
      gnt_q <= 2'b00;
      ack_q <= 2'b00;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|win) begin
            owner  <= sel;
            last   <= sel;
            gnt_q  <= win;
            busy_q <= 1'b1;
            if (sel_oor) begin
              state <= S_ERR;
            end else if (sel_we) begin
              state      <= S_WR;
              mem_we_q   <= 1'b1;
              mem_addr_q <= sel_addr;
              mem_di_q   <= sel_wdata;
            end else begin
              state      <= S_RD;
              mem_e_q    <= 1'b1;
              mem_addr_q <= sel_addr;
            end
          end
        end
        S_WR: begin
          state      <= S_IDLE;
          busy_q     <= 1'b0;
          mem_we_q   <= 1'b0;
          mem_addr_q <= '0;
          mem_di_q   <= '0;
          ack_q      <= port_onehot(owner);
        end
        S_RD: begin
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          state      <= S_IDLE;
          busy_q     <= 1'b0;
          mem_e_q    <= 1'b0;
          mem_addr_q <= '0;
          rdata_q    <= bus.mem_do_i;
          ack_q      <= port_onehot(owner);
        end
        S_ERR: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b1;
          rdata_q <= '0;
          ack_q   <= port_onehot(owner);
        end
        default: begin
          state      <= S_IDLE;
          busy_q     <= 1'b0;
          mem_e_q    <= 1'b0;
          mem_we_q   <= 1'b0;
          mem_addr_q <= '0;
          mem_di_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.ack_o      = ack_q;
  assign bus.err_o      = err_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.busy_o     = busy_q;
  assign bus.mem_e_o    = mem_e_q;
  assign bus.mem_we_o   = mem_we_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_di_o   = mem_di_q;

endmodule
